error_event_queue: RTL and testbench
====================================

Name: error_event_queue

Overview:
- Upstream producer for event-driven checkers and monitors. Converts a level-sensitive error flag into discrete, timestamped error events.
- Each 0->1 transition of the error flag is one event, stamped with a free-running cycle timestamp.
- Events are buffered in a small FIFO and handed to a consumer over a valid/ready handshake.
- Overflow and event counts are kept so that no error occurrence goes unaccounted for.

Parameters:
- TS_W, 16, width of the free-running timestamp counter and of evt_ts_o
- DEPTH, 4, FIFO entries; must be a power of two, >= 2
- CNT_W, 8, width of evt_count_o and drop_count_o (saturating)

Ports:
- clk  input  1  single clock; all logic on the rising edge
- rst  input  1  reset, synchronous, active-high
- error_i  input  1  level error flag, synchronous to clk
- clr_i  input  1  one-cycle pulse; clears counters and the overflow flag
- evt_valid_o  output  1  FIFO head holds an event
- evt_ready_i  input  1  consumer accepts the head; pop occurs when evt_valid_o & evt_ready_i
- evt_ts_o  output  TS_W  timestamp of the head entry; 0 when evt_valid_o=0
- evt_count_o  output  CNT_W  total rising edges detected, including dropped ones; saturating
- drop_count_o  output  CNT_W  events lost to a full FIFO; saturating
- overflow_o  output  1  sticky; set on the first drop

Behaviour:
- Reset (rst=1 at a clock edge):
  - ts=0, err_q=0, FIFO empty (rd/wr pointers 0)
  - evt_valid_o=0, evt_ts_o=0, evt_count_o=0, drop_count_o=0, overflow_o=0
  - Reset mid-operation discards all queued events, with no drop accounting.
- Timestamp:
  - ts increments by 1 every non-reset cycle and wraps 2^TS_W-1 -> 0.
- Edge detection:
  - err_q <= error_i each cycle; edge = error_i & ~err_q.
  - Because err_q resets to 0, error_i=1 in the first cycle after reset counts as an edge.
  - A level held high produces exactly one event.
  - Toggling 0/1 every cycle produces one event every two cycles.
- Push:
  - On an edge in cycle n, the entry value is the ts register value in cycle n.
  - The entry is written at the end of cycle n and visible at cycle n+1. Latency is 1 cycle edge->evt_valid_o when the FIFO was empty.
- FIFO:
  - Show-ahead: evt_ts_o always reflects the head entry.
  - Occupancy is tracked with pointers one bit wider than log2(DEPTH); full = MSBs differ and the remaining bits are equal.
  - Pop and push in the same cycle are both performed; occupancy is unchanged.
  - Full with pop and push in the same cycle: the push is accepted, not dropped (the pop frees a slot in the same cycle).
  - Full with push and no pop: the event is dropped, drop_count_o += 1 (saturating), overflow_o <= 1.
  - Empty: evt_ready_i is ignored and no pointer moves.
- evt_count_o:
  - +1 on every edge, whether pushed or dropped.
  - Holds at 2^CNT_W-1 once reached.
- clr_i:
  - Zeroes evt_count_o, drop_count_o and overflow_o.
  - Does not flush the FIFO and does not reset ts.
  - clr_i together with an edge: clear takes priority, then the edge is counted. Result is evt_count_o=1; if that edge is also dropped, drop_count_o=1 and overflow_o=1.
  - rst dominates clr_i.
- Handshake rules:
  - evt_valid_o, once high, stays high until popped. It never deasserts without a pop, except on rst.
  - evt_ts_o is stable while evt_valid_o=1 and evt_ready_i=0.
- All outputs are registered or derived only from registered state. There is no combinational path from error_i to any output.

Test Plan:
- Reset-release edge: rst 1->0 with error_i=1 held; evt_ready_i=0 -> evt_valid_o=1 one cycle later with evt_ts_o=0, evt_count_o=1; holding error_i high 20 cycles adds no events.
- Pulse train: error_i high for 1 cycle at ts=10, 30, 60, 100; evt_ready_i=1 -> four pops with evt_ts_o=10, 30, 60, 100, each evt_valid_o asserted exactly 1 cycle after its edge; evt_count_o=4, drop_count_o=0.
- Overflow: DEPTH=4, evt_ready_i=0, 6 separated edges -> FIFO holds the first 4 timestamps in order; drop_count_o=2, overflow_o=1, evt_count_o=6. Then clr_i -> counters 0, overflow_o=0, and the 4 entries still drain correctly.
- Full with simultaneous pop/push: FIFO full, evt_ready_i=1 in the same cycle as a new edge at ts=T -> no drop; occupancy stays 4; T is the last entry popped.
- Saturation and wrap: CNT_W=3, TS_W=4, 10 edges with evt_ready_i=1 -> evt_count_o stops at 7; timestamps crossing 15 wrap to 0,1,...; drop_count_o=0.
- Mid-operation reset: 3 queued events, then rst for 1 cycle -> evt_valid_o=0 and all counters 0 next cycle; the next edge is stamped with post-reset ts starting from 0.

Source files
------------

// File: rtl/error_event_queue.sv
// error_event_queue
// Turns a level-sensitive error flag into discrete timestamped events.
// Each 0->1 transition of error_i is stamped with a free-running cycle counter.
// The stamp goes into a show-ahead FIFO that a consumer drains over valid/ready.
// Saturating counters record every edge and every event lost to a full FIFO.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   error_i       level error flag (synchronous to clk)
//   clr_i         one-cycle pulse; clears evt_count_o, drop_count_o, overflow_o
//   evt_valid_o   FIFO head holds an event
//   evt_ready_i   consumer accepts the head (pop on valid & ready)
//   evt_ts_o      timestamp of the head entry, 0 when the FIFO is empty
//   evt_count_o   saturating count of all detected edges
//   drop_count_o  saturating count of edges lost to a full FIFO
//   overflow_o    sticky flag, set on the first drop
//
// DEPTH must be a power of two and at least 2.
module error_event_queue #(
  parameter int unsigned TS_W  = 16,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             error_i,
  input  logic             clr_i,
  output logic             evt_valid_o,
  input  logic             evt_ready_i,
  output logic [TS_W-1:0]  evt_ts_o,
  output logic [CNT_W-1:0] evt_count_o,
  output logic [CNT_W-1:0] drop_count_o,
  output logic             overflow_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [TS_W-1:0]  ts;
  logic             err_q;
  logic [TS_W-1:0]  mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CNT_W-1:0] evt_cnt;
  logic [CNT_W-1:0] drop_cnt;
  logic             ovf;

  logic             err_edge;
  logic             empty;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;
  logic [CNT_W-1:0] evt_cnt_nxt;
  logic [CNT_W-1:0] drop_cnt_nxt;
  logic             ovf_nxt;

  // Edge detect and FIFO status; full uses the extra pointer wrap bit.
  always_comb begin
    err_edge = error_i & ~err_q;
    empty    = (rd_ptr == wr_ptr);
    full     = (rd_ptr[AW] != wr_ptr[AW]) &&
               (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]);
    pop      = ~empty & evt_ready_i;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    push     = err_edge & (~full | pop);
    drop     = err_edge & full & ~pop;
  end

  // Counter next-state: clear is applied first, then this cycle's edge/drop.
  always_comb begin
    evt_cnt_nxt  = clr_i ? '0 : evt_cnt;
    drop_cnt_nxt = clr_i ? '0 : drop_cnt;
    ovf_nxt      = clr_i ? 1'b0 : ovf;
    if (err_edge && (evt_cnt_nxt != {CNT_W{1'b1}})) begin
      evt_cnt_nxt = evt_cnt_nxt + CNT_W'(1);
    end
    if (drop) begin
      ovf_nxt = 1'b1;
      if (drop_cnt_nxt != {CNT_W{1'b1}}) begin
        drop_cnt_nxt = drop_cnt_nxt + CNT_W'(1);
      end
    end
  end

  // Timestamp, edge history, pointers and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts       <= '0;
      err_q    <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      evt_cnt  <= '0;
      drop_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      ts       <= ts + TS_W'(1);
      err_q    <= error_i;
      evt_cnt  <= evt_cnt_nxt;
      drop_cnt <= drop_cnt_nxt;
      ovf      <= ovf_nxt;
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
    end
  end

  // FIFO storage; contents are only observed through the pointers.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr[AW-1:0]] <= ts;
    end
  end

  // Outputs derive from registered state only.
  always_comb begin
    evt_valid_o  = ~empty;
    evt_ts_o     = empty ? '0 : mem[rd_ptr[AW-1:0]];
    evt_count_o  = evt_cnt;
    drop_count_o = drop_cnt;
    overflow_o   = ovf;
  end

endmodule

// File: tb/tb_error_event_queue.sv
// Scoreboard bench for error_event_queue: a default-parameter instance and a
// small instance (TS_W=4, CNT_W=3) for saturation and timestamp wrap.
module tb_error_event_queue;

  typedef struct {
    int ts;
    int at;   // cycle the pop must happen in, -1 when not constrained
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance
  logic        rst = 1'b1;
  logic        error_i = 1'b0;
  logic        clr_i = 1'b0;
  logic        evt_ready_i = 1'b0;
  logic        evt_valid_o;
  logic [15:0] evt_ts_o;
  logic [7:0]  evt_count_o;
  logic [7:0]  drop_count_o;
  logic        overflow_o;

  // Small instance
  logic        s_rst = 1'b1;
  logic        s_error = 1'b0;
  logic        s_clr = 1'b0;
  logic        s_ready = 1'b1;
  logic        s_valid;
  logic [3:0]  s_ts_o;
  logic [2:0]  s_count;
  logic [2:0]  s_drop;
  logic        s_ovf;

  error_event_queue #(.TS_W(16), .DEPTH(4), .CNT_W(8)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .error_i      (error_i),
    .clr_i        (clr_i),
    .evt_valid_o  (evt_valid_o),
    .evt_ready_i  (evt_ready_i),
    .evt_ts_o     (evt_ts_o),
    .evt_count_o  (evt_count_o),
    .drop_count_o (drop_count_o),
    .overflow_o   (overflow_o)
  );

  error_event_queue #(.TS_W(4), .DEPTH(4), .CNT_W(3)) u_sat (
    .clk          (clk),
    .rst          (s_rst),
    .error_i      (s_error),
    .clr_i        (s_clr),
    .evt_valid_o  (s_valid),
    .evt_ready_i  (s_ready),
    .evt_ts_o     (s_ts_o),
    .evt_count_o  (s_count),
    .drop_count_o (s_drop),
    .overflow_o   (s_ovf)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   tb_ts = 0;
  int   s_tb_ts = 0;
  exp_t exp_q[$];
  exp_t s_q[$];

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference cycle counters: tb_ts tracks the DUT timestamp register.
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    tb_ts   <= rst ? 0 : tb_ts + 1;
    s_tb_ts <= s_rst ? 0 : s_tb_ts + 1;
  end

  // Main monitor: pops the scoreboard on every accepted head.
  logic hold_v = 1'b0;
  int   hold_ts = 0;
  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (evt_valid_o && evt_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop: got ts %0d expected no event", evt_ts_o);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("pop_ts", int'(evt_ts_o), e.ts);
          if (e.at >= 0) check("pop_latency", cyc, e.at);
        end
      end
      if (!evt_valid_o) check("idle_ts_zero", int'(evt_ts_o), 0);
      if (hold_v) begin
        check("valid_hold", int'(evt_valid_o), 1);
        check("ts_stable", int'(evt_ts_o), hold_ts);
      end
      hold_v  = evt_valid_o & ~evt_ready_i;
      hold_ts = int'(evt_ts_o);
    end
  end

  // Small-instance monitor.
  always @(negedge clk) begin
    if (!s_rst) begin
      if (s_valid && s_ready) begin
        if (s_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL s_unexpected_pop: got ts %0d expected no event", s_ts_o);
        end else begin
          exp_t e;
          e = s_q.pop_front();
          check("s_pop_ts", int'(s_ts_o), e.ts);
          if (e.at >= 0) check("s_pop_latency", cyc, e.at);
        end
      end
      if (!s_valid) check("s_idle_ts_zero", int'(s_ts_o), 0);
    end
  end

  task automatic wait_ts(input int t);
    int guard = 0;
    while (tb_ts != t && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (tb_ts != t) check("ts_sync", tb_ts, t);
  endtask

  // One-cycle error pulse in the cycle where the timestamp equals t.
  task automatic pulse_at(input int t, input bit push_exp, input bit lat);
    wait_ts(t);
    error_i = 1'b1;
    if (push_exp) exp_q.push_back('{ts: t, at: (lat ? cyc + 1 : -1)});
    @(posedge clk); #1;
    error_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_cnt(input string tag, input int ec, input int dc, input int ov);
    @(negedge clk);
    check({tag, "_evt_count"}, int'(evt_count_o), ec);
    check({tag, "_drop_count"}, int'(drop_count_o), dc);
    check({tag, "_overflow"}, int'(overflow_o), ov);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

  int sat_exp[10] = '{2, 5, 8, 11, 14, 1, 4, 7, 10, 13};

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_valid", int'(evt_valid_o), 0);
    check("rst_ts", int'(evt_ts_o), 0);
    check("rst_evt_count", int'(evt_count_o), 0);
    check("rst_drop_count", int'(drop_count_o), 0);
    check("rst_overflow", int'(overflow_o), 0);

    // Reset release with error_i already high: edge at ts 0
    @(posedge clk); #1;
    rst = 1'b0;
    error_i = 1'b1;
    exp_q.push_back('{ts: 0, at: -1});
    @(negedge clk);
    check("release_valid_latency", int'(evt_valid_o), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("release_valid", int'(evt_valid_o), 1);
    check("release_ts", int'(evt_ts_o), 0);
    check("release_count", int'(evt_count_o), 1);
    repeat (20) @(posedge clk);
    #1;
    check_cnt("level_held", 1, 0, 0);
    error_i = 1'b0;
    evt_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("release_drained", int'(evt_valid_o), 0);

    // Pulse train with consumer always ready
    do_reset();
    evt_ready_i = 1'b1;
    pulse_at(10, 1'b1, 1'b1);
    pulse_at(30, 1'b1, 1'b1);
    pulse_at(60, 1'b1, 1'b1);
    pulse_at(100, 1'b1, 1'b1);
    wait_ts(105);
    check_cnt("train", 4, 0, 0);
    check("train_q_empty", exp_q.size(), 0);

    // Overflow: six edges into a 4-deep FIFO with no consumer
    do_reset();
    evt_ready_i = 1'b0;
    pulse_at(5, 1'b1, 1'b0);
    pulse_at(10, 1'b1, 1'b0);
    pulse_at(15, 1'b1, 1'b0);
    pulse_at(20, 1'b1, 1'b0);
    pulse_at(25, 1'b0, 1'b0);
    pulse_at(30, 1'b0, 1'b0);
    wait_ts(35);
    check_cnt("ovf", 6, 2, 1);
    check("ovf_valid", int'(evt_valid_o), 1);
    check("ovf_head", int'(evt_ts_o), 5);
    wait_ts(40);
    clr_i = 1'b1;
    @(posedge clk); #1;
    clr_i = 1'b0;
    check_cnt("clr", 0, 0, 0);
    check("clr_keeps_fifo", int'(evt_valid_o), 1);
    // Clear together with an edge that is dropped
    wait_ts(50);
    clr_i = 1'b1;
    error_i = 1'b1;
    @(posedge clk); #1;
    clr_i = 1'b0;
    error_i = 1'b0;
    check_cnt("clr_edge", 1, 1, 1);
    wait_ts(55);
    evt_ready_i = 1'b1;
    wait_ts(62);
    check("ovf_drain_empty", int'(evt_valid_o), 0);
    check("ovf_q_empty", exp_q.size(), 0);

    // Full FIFO with pop and push in the same cycle
    do_reset();
    evt_ready_i = 1'b0;
    pulse_at(5, 1'b1, 1'b0);
    pulse_at(10, 1'b1, 1'b0);
    pulse_at(15, 1'b1, 1'b0);
    pulse_at(20, 1'b1, 1'b0);
    wait_ts(30);
    error_i = 1'b1;
    evt_ready_i = 1'b1;
    exp_q.push_back('{ts: 30, at: -1});
    @(posedge clk); #1;
    error_i = 1'b0;
    evt_ready_i = 1'b0;
    wait_ts(35);
    check_cnt("full_pp", 5, 0, 0);
    pulse_at(40, 1'b0, 1'b0);
    wait_ts(45);
    check_cnt("full_still", 6, 1, 1);
    evt_ready_i = 1'b1;
    wait_ts(52);
    check("full_drain_empty", int'(evt_valid_o), 0);
    check("full_q_empty", exp_q.size(), 0);

    // Mid-operation reset discards queued events
    do_reset();
    evt_ready_i = 1'b0;
    pulse_at(5, 1'b1, 1'b0);
    pulse_at(10, 1'b1, 1'b0);
    pulse_at(15, 1'b1, 1'b0);
    wait_ts(20);
    clr_i = 1'b1;
    do_reset();
    clr_i = 1'b0;
    @(negedge clk);
    check("midrst_valid", int'(evt_valid_o), 0);
    check("midrst_evt_count", int'(evt_count_o), 0);
    check("midrst_drop_count", int'(drop_count_o), 0);
    check("midrst_overflow", int'(overflow_o), 0);
    evt_ready_i = 1'b1;
    pulse_at(3, 1'b1, 1'b1);
    wait_ts(8);
    check_cnt("midrst_after", 1, 0, 0);
    check("midrst_q_empty", exp_q.size(), 0);
    evt_ready_i = 1'b0;

    // Small instance: counter saturation at 7, timestamp wrap at 16
    @(posedge clk); #1;
    s_rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      int guard = 0;
      while (s_tb_ts != 2 + 3 * k && guard < 200) begin
        @(posedge clk); #1;
        guard++;
      end
      if (s_tb_ts != 2 + 3 * k) check("s_ts_sync", s_tb_ts, 2 + 3 * k);
      s_error = 1'b1;
      s_q.push_back('{ts: sat_exp[k], at: cyc + 1});
      @(posedge clk); #1;
      s_error = 1'b0;
      if (k == 6) begin
        @(negedge clk);
        check("s_count_at7", int'(s_count), 7);
      end
    end
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    check("s_count_sat", int'(s_count), 7);
    check("s_drop_count", int'(s_drop), 0);
    check("s_overflow", int'(s_ovf), 0);
    check("s_q_empty", s_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
